// File: rtl/card_shoe_if.sv
// Bundles the request/refill controls and the dealt-card outputs of card_shoe.
// The master drives req/reshuffle; the slave (the shoe) drives everything else.
interface card_shoe_if;
    logic       req;
    logic       reshuffle;
    logic [3:0] card;
    logic       card_valid;
    logic       busy;
    logic       empty;
    logic [8:0] remaining;
    logic       dbg_state;

    modport master (
        output req, reshuffle,
        input  card, card_valid, busy, empty, remaining, dbg_state
    );

    modport slave (
        input  req, reshuffle,
        output card, card_valid, busy, empty, remaining, dbg_state
    );
endinterface

// File: rtl/card_shoe.sv
// NDECKS-deck card shoe: per-rank remaining counts, one card dealt per accepted request.
// The dealt rank is the first non-empty rank at or after a free-running 1..13 counter.
module card_shoe #(
    parameter int NDECKS = 1
) (
    input  logic        clock,
    input  logic        resetb,
    card_shoe_if.slave  bus
);
    localparam logic [5:0] RANK_INIT = 6'(4 * NDECKS);
    localparam logic [8:0] SHOE_INIT = 9'(52 * NDECKS);

    typedef enum logic {IDLE = 1'b0, SEARCH = 1'b1} state_e;

    state_e     state_q, state_d;
    logic [3:0] rng_q, rng_d;
    logic [3:0] ptr_q, ptr_d;
    logic [3:0] card_q, card_d;
    logic       valid_q, valid_d;
    logic [5:0] rem_q [1:13];
    logic [5:0] rem_d [1:13];
    logic [8:0] remaining_q, remaining_d;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q     <= IDLE;
            rng_q       <= 4'd1;
            ptr_q       <= 4'd1;
            card_q      <= 4'd0;
            valid_q     <= 1'b0;
            remaining_q <= SHOE_INIT;
            for (int i = 1; i <= 13; i++) rem_q[i] <= RANK_INIT;
        end else begin
            state_q     <= state_d;
            rng_q       <= rng_d;
            ptr_q       <= ptr_d;
            card_q      <= card_d;
            valid_q     <= valid_d;
            remaining_q <= remaining_d;
            rem_q       <= rem_d;
        end
    end

    // Handshake: req is taken only in IDLE with a non-empty shoe; the result is
    // returned as a single-cycle card_valid pulse, and req seen while busy is dropped.
    always_comb begin
        state_d     = state_q;
        rng_d       = (rng_q == 4'd13) ? 4'd1 : rng_q + 4'd1;
        ptr_d       = ptr_q;
        card_d      = card_q;
        valid_d     = 1'b0;
        remaining_d = remaining_q;
        rem_d       = rem_q;

        if (bus.reshuffle) begin
            state_d     = IDLE;
            card_d      = 4'd0;
            remaining_d = SHOE_INIT;
            for (int i = 1; i <= 13; i++) rem_d[i] = RANK_INIT;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req && (remaining_q != 9'd0)) begin
                        ptr_d   = rng_q;
                        state_d = SEARCH;
                    end
                end
                SEARCH: begin
                    if (rem_q[ptr_q] != 6'd0) begin
                        card_d       = ptr_q;
                        rem_d[ptr_q] = rem_q[ptr_q] - 6'd1;
                        remaining_d  = remaining_q - 9'd1;
                        valid_d      = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        // Entry requires a non-empty shoe, so this walk always ends on a hit.
                        ptr_d = (ptr_q == 4'd13) ? 4'd1 : ptr_q + 4'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.card       = card_q;
    assign bus.card_valid = valid_q;
    assign bus.busy       = (state_q == SEARCH);
    assign bus.empty      = (remaining_q == 9'd0);
    assign bus.remaining  = remaining_q;
    assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_card_shoe.sv
// Self-checking bench for card_shoe (NDECKS = 1) against a per-rank count model
// that predicts each dealt rank and its latency from the captured counter value.
module tb_card_shoe;
    logic clock;
    logic resetb;

    card_shoe_if bus ();

    card_shoe #(.NDECKS(1)) dut (
        .clock  (clock),
        .resetb (resetb),
        .bus    (bus)
    );

    int errors = 0;
    int checks = 0;
    int edges  = 0;
    int ref_rem [1:13];
    int ref_remaining;
    int seen [1:13];
    int last_card;
    int last_lat;
    logic [3:0] exp_q [$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Edges since reset release: the shoe's counter value before the next edge is edges%13+1.
    always @(posedge clock or negedge resetb) begin
        if (!resetb) edges <= 0;
        else         edges <= edges + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_refill();
        for (int r = 1; r <= 13; r++) begin
            ref_rem[r] = 4;
            seen[r]    = 0;
        end
        ref_remaining = 52;
    endtask

    task automatic align(input int r);
        int guard = 0;
        while (((edges % 13) + 1) != r && guard < 30) begin
            @(posedge clock); #1;
            guard++;
        end
    endtask

    task automatic do_reshuffle();
        bus.reshuffle = 1'b1;
        @(posedge clock); #1;
        bus.reshuffle = 1'b0;
        model_refill();
        check("reshuffle_card", bus.card, 0);
        check("reshuffle_valid", bus.card_valid, 0);
        check("reshuffle_busy", bus.busy, 0);
        check("reshuffle_remaining", bus.remaining, 52);
        check("reshuffle_empty", bus.empty, 0);
    endtask

    // One accepted request; expectations come from scanning the model counts.
    task automatic deal(input bit toggle);
        int r;
        int exp_card = 0;
        int exp_lat = 0;
        int n;
        logic [3:0] exp_v;
        r = (edges % 13) + 1;
        for (int k = 0; k < 13; k++) begin
            int rank;
            rank = ((r - 1 + k) % 13) + 1;
            if (exp_card == 0 && ref_rem[rank] > 0) begin
                exp_card = rank;
                exp_lat  = 2 + k;
            end
        end
        exp_q.push_back(4'(exp_card));
        bus.req = 1'b1;
        @(posedge clock); #1;
        bus.req = toggle ? 1'($urandom_range(0, 1)) : 1'b0;
        check("busy_after_req", bus.busy, 1);
        n = 1;
        while (bus.card_valid !== 1'b1 && n < 20) begin
            @(posedge clock); #1;
            n++;
            bus.req = (toggle && bus.card_valid !== 1'b1) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        bus.req = 1'b0;
        exp_v = exp_q.pop_front();
        check("deal_valid", bus.card_valid, 1);
        check("deal_card", bus.card, exp_v);
        check("deal_latency", n, exp_lat);
        last_card = bus.card;
        last_lat  = n;
        if (exp_card != 0) begin
            ref_rem[exp_card]--;
            ref_remaining--;
            seen[exp_card]++;
        end
        check("deal_remaining", bus.remaining, ref_remaining);
        check("deal_busy_low", bus.busy, 0);
        @(posedge clock); #1;
        check("valid_one_cycle", bus.card_valid, 0);
        check("card_holds", bus.card, exp_v);
    endtask

    initial begin
        int vcount;
        logic [3:0] held;
        bus.req       = 1'b0;
        bus.reshuffle = 1'b0;
        resetb        = 1'b1;

        // Reset values, asserted mid-cycle.
        #3 resetb = 1'b0;
        #1;
        model_refill();
        check("rst_card", bus.card, 0);
        check("rst_valid", bus.card_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_empty", bus.empty, 0);
        check("rst_remaining", bus.remaining, 52);
        check("rst_state", bus.dbg_state, 0);
        repeat (3) @(posedge clock);
        #5 resetb = 1'b1;

        // First deal: request at edge 1 captures rank 1.
        deal(1'b0);
        check("first_card", last_card, 1);
        check("first_latency", last_lat, 2);

        // Exhaust rank 1, fifth request walks one step to rank 2.
        do_reshuffle();
        for (int i = 0; i < 5; i++) begin
            align(1);
            deal(1'b0);
            if (i < 4) check("rank1_card", last_card, 1);
        end
        check("rank1_exhaust_card", last_card, 2);
        check("rank1_exhaust_latency", last_lat, 3);

        // Drain with random gaps between requests.
        while (ref_remaining > 0) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clock); #1;
            end
            deal(1'b0);
        end
        for (int r = 1; r <= 13; r++) check("drain_rank_count", seen[r], 4);
        check("drain_remaining", bus.remaining, 0);
        check("drain_empty", bus.empty, 1);

        // Request on an empty shoe is ignored.
        held = bus.card;
        bus.req = 1'b1;
        @(posedge clock); #1;
        bus.req = 1'b0;
        check("empty_req_busy", bus.busy, 0);
        vcount = 0;
        repeat (15) begin
            @(posedge clock); #1;
            if (bus.card_valid === 1'b1) vcount++;
        end
        check("empty_req_no_valid", vcount, 0);
        check("empty_req_card", bus.card, held);

        // Reshuffle with req during a miss cycle aborts the search.
        do_reshuffle();
        for (int i = 0; i < 4; i++) begin
            align(1);
            deal(1'b0);
        end
        align(1);
        bus.req = 1'b1;
        @(posedge clock); #1;
        check("abort_busy_before", bus.busy, 1);
        bus.reshuffle = 1'b1;
        bus.req       = 1'b1;
        @(posedge clock); #1;
        bus.reshuffle = 1'b0;
        bus.req       = 1'b0;
        model_refill();
        check("abort_busy", bus.busy, 0);
        check("abort_card", bus.card, 0);
        check("abort_valid", bus.card_valid, 0);
        check("abort_remaining", bus.remaining, 52);
        check("abort_empty", bus.empty, 0);
        vcount = 0;
        repeat (15) begin
            @(posedge clock); #1;
            if (bus.card_valid === 1'b1 || bus.busy === 1'b1) vcount++;
        end
        check("abort_no_deal", vcount, 0);

        // Worst case: only one rank-13 card left, captured counter 1, req toggling.
        for (int r = 1; r <= 13; r++) begin
            for (int i = 0; i < ((r == 13) ? 3 : 4); i++) begin
                align(r);
                deal(1'b0);
            end
        end
        align(1);
        deal(1'b1);
        check("worst_card", last_card, 13);
        check("worst_latency", last_lat, 14);
        check("worst_remaining", bus.remaining, 0);

        // Reset asserted mid-search returns everything to its initial values.
        do_reshuffle();
        for (int i = 0; i < 4; i++) begin
            align(1);
            deal(1'b0);
        end
        align(1);
        bus.req = 1'b1;
        @(posedge clock); #1;
        bus.req = 1'b0;
        check("midsearch_busy", bus.busy, 1);
        #2 resetb = 1'b0;
        #1;
        model_refill();
        check("midrst_busy", bus.busy, 0);
        check("midrst_card", bus.card, 0);
        check("midrst_valid", bus.card_valid, 0);
        check("midrst_remaining", bus.remaining, 52);
        check("midrst_state", bus.dbg_state, 0);
        repeat (2) @(posedge clock);
        #5 resetb = 1'b1;
        deal(1'b0);
        check("post_reset_card", last_card, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
